// File: rtl/dshot_pkg.sv
// Shared DShot definitions: rate encoding, per-rate bit timing and frame CRC.
package dshot_pkg;

   typedef enum logic [1:0] {
      MODE_150  = 2'd0,
      MODE_300  = 2'd1,
      MODE_600  = 2'd2,
      MODE_1200 = 2'd3
   } dshot_mode_e;

   localparam int FRAME_BITS = 16;
   localparam int CNT_W      = 7;

   // Bit timing in 16 MHz clock cycles.
   localparam logic [CNT_W-1:0] PERIOD_150  = 7'd107;
   localparam logic [CNT_W-1:0] PERIOD_300  = 7'd53;
   localparam logic [CNT_W-1:0] PERIOD_600  = 7'd27;
   localparam logic [CNT_W-1:0] PERIOD_1200 = 7'd13;
   localparam logic [CNT_W-1:0] T1H_150     = 7'd80;
   localparam logic [CNT_W-1:0] T1H_300     = 7'd40;
   localparam logic [CNT_W-1:0] T1H_600     = 7'd20;
   localparam logic [CNT_W-1:0] T1H_1200    = 7'd10;
   localparam logic [CNT_W-1:0] T0H_150     = 7'd40;
   localparam logic [CNT_W-1:0] T0H_300     = 7'd20;
   localparam logic [CNT_W-1:0] T0H_600     = 7'd10;
   localparam logic [CNT_W-1:0] T0H_1200    = 7'd5;

   function automatic logic [CNT_W-1:0] period_of(input dshot_mode_e m);
      case (m)
         MODE_150:  return PERIOD_150;
         MODE_300:  return PERIOD_300;
         MODE_600:  return PERIOD_600;
         default:   return PERIOD_1200;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] t1h_of(input dshot_mode_e m);
      case (m)
         MODE_150:  return T1H_150;
         MODE_300:  return T1H_300;
         MODE_600:  return T1H_600;
         default:   return T1H_1200;
      endcase
   endfunction

   function automatic logic [CNT_W-1:0] t0h_of(input dshot_mode_e m);
      case (m)
         MODE_150:  return T0H_150;
         MODE_300:  return T0H_300;
         MODE_600:  return T0H_600;
         default:   return T0H_1200;
      endcase
   endfunction

   // XOR of the three nibbles of {throttle, telem}.
   function automatic logic [3:0] crc4(input logic [11:0] v);
      return v[3:0] ^ v[7:4] ^ v[11:8];
   endfunction

endpackage

// File: rtl/dshot_ch_shifter.sv
// Per-channel frame holder: loads a 16-bit frame and presents bits MSB first.
module dshot_ch_shifter
   import dshot_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [FRAME_BITS-1:0] load_val,
   output logic                  msb
);

   logic [FRAME_BITS-1:0] sreg_q;

   // Load on accept, advance one bit at each bit-period end.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg_q <= '0;
      end else if (load) begin
         sreg_q <= load_val;
      end else if (shift) begin
         sreg_q <= {sreg_q[FRAME_BITS-2:0], 1'b0};
      end
   end

   assign msb = sreg_q[FRAME_BITS-1];

endmodule

// File: rtl/dshot_tx_multi.sv
// Multi-channel DShot transmitter: shared sequencer, per-channel shifters.
//
// state  | meaning
// IDLE   | ready for a frame set, outputs low
// BIT    | serialising 16 bits, cyc_q is position within the bit period
// GAP    | enforced low idle time before the next accept
module dshot_tx_multi
   import dshot_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int GAP_CYCLES = 64,
   parameter int CLK_HZ     = 16000000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [1:0]          mode,
   input  logic [11*NUM_CH-1:0] throttle,
   input  logic [NUM_CH-1:0]   telem,
   input  logic                frame_valid,
   output logic                frame_ready,
   output logic                busy,
   output logic [NUM_CH-1:0]   dshot_out
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   if (CLK_HZ != 16000000) begin : g_bad_clk
      $error("dshot_tx_multi: timing table only valid for a 16 MHz clock");
   end
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
      $error("dshot_tx_multi: NUM_CH must be 1..8");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("dshot_tx_multi: GAP_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_BIT, ST_GAP} state_e;

   state_e             state_q, state_d;
   dshot_mode_e        mode_q;
   logic [CNT_W-1:0]   cyc_q;
   logic [3:0]         bit_q;
   logic [GAP_W-1:0]   gap_q;
   logic [CNT_W-1:0]   period_cur, t1h_cur, t0h_cur;
   logic               accept, bit_end, last_bit;
   logic [NUM_CH-1:0]  msb;

   assign period_cur = period_of(mode_q);
   assign t1h_cur    = t1h_of(mode_q);
   assign t0h_cur    = t0h_of(mode_q);
   assign accept     = frame_ready & frame_valid;
   assign bit_end    = (state_q == ST_BIT) && (cyc_q == period_cur - 7'd1);
   assign last_bit   = (bit_q == 4'(FRAME_BITS - 1));

   // Next-state and state-decoded handshake outputs.
   always_comb begin
      state_d     = state_q;
      frame_ready = 1'b0;
      busy        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            frame_ready = 1'b1;
            busy        = 1'b0;
            if (frame_valid) state_d = ST_BIT;
         end
         ST_BIT: begin
            if (bit_end && last_bit) state_d = ST_GAP;
         end
         ST_GAP: begin
            if (gap_q == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register plus shared bit/cycle/gap counters.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_150;
         cyc_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mode_q <= dshot_mode_e'(mode);
            cyc_q  <= '0;
            bit_q  <= '0;
         end else if (state_q == ST_BIT) begin
            if (bit_end) begin
               cyc_q <= '0;
               bit_q <= bit_q + 4'd1;
            end else begin
               cyc_q <= cyc_q + 7'd1;
            end
         end
         if (bit_end && last_bit) begin
            gap_q <= GAP_W'(GAP_CYCLES - 1);
         end else if (state_q == ST_GAP && gap_q != '0) begin
            gap_q <= gap_q - GAP_W'(1);
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [11:0] v;
      assign v = {throttle[11*i +: 11], telem[i]};

      dshot_ch_shifter u_shifter (
         .clk      (CLK),
         .rst      (RST),
         .load     (accept),
         .shift    (bit_end),
         .load_val ({v, crc4(v)}),
         .msb      (msb[i])
      );
   end

   // Registered pin drive: high while the shared counter is inside the bit's high time.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dshot_out <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            dshot_out[i] <= (state_q == ST_BIT) && (cyc_q < (msb[i] ? t1h_cur : t0h_cur));
         end
      end
   end

endmodule

// File: tb/tb_dshot_tx_multi.sv
// Self-checking bench: cycle-level reference model of the DShot waveform.
module tb_dshot_tx_multi;

   localparam int NUM_CH = 4;
   localparam int GAP    = 64;

   logic                    CLK = 1'b0;
   logic                    RST;
   logic [1:0]              mode;
   logic [11*NUM_CH-1:0]    throttle;
   logic [NUM_CH-1:0]       telem;
   logic                    frame_valid;
   logic                    frame_ready;
   logic                    busy;
   logic [NUM_CH-1:0]       dshot_out;

   dshot_tx_multi #(.NUM_CH(NUM_CH), .GAP_CYCLES(GAP), .CLK_HZ(16000000)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .mode        (mode),
      .throttle    (throttle),
      .telem       (telem),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .busy        (busy),
      .dshot_out   (dshot_out)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // model state: m_t counts edges since the accept edge
   bit          m_active = 1'b0;
   int          m_t = 0;
   int          m_p = 27, m_t1 = 20, m_t0 = 10;
   logic [15:0] m_frame [NUM_CH];

   int cyc = 0;
   int busy_cnt = 0;
   bit busy_prev = 1'b0;
   int run = 0;
   int starts[$];
   int widths[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int period_of(input int md);
      case (md)
         0: return 107;
         1: return 53;
         2: return 27;
         default: return 13;
      endcase
   endfunction

   function automatic int t1h_of(input int md);
      case (md)
         0: return 80;
         1: return 40;
         2: return 20;
         default: return 10;
      endcase
   endfunction

   function automatic logic [15:0] build(input int thr, input bit tl);
      int v, crc;
      v   = thr * 2 + int'(tl);
      crc = (v ^ (v >> 4) ^ (v >> 8)) & 15;
      return 16'(v * 16 + crc);
   endfunction

   task automatic set_thr(input int c, input int val);
      throttle[11*c +: 11] = 11'(val);
   endtask

   // Advance one clock: predict the edge from current inputs, then compare.
   task automatic step();
      logic [NUM_CH-1:0] exp_out;
      if (RST) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (frame_valid) begin
            m_active = 1'b1;
            m_t      = 0;
            m_p      = period_of(int'(mode));
            m_t1     = t1h_of(int'(mode));
            m_t0     = m_t1 / 2;
            for (int c = 0; c < NUM_CH; c++)
               m_frame[c] = build(int'(throttle[11*c +: 11]), telem[c]);
         end
      end else begin
         m_t++;
         if (m_t >= 16*m_p + GAP) m_active = 1'b0;
      end
      @(posedge CLK);
      #1;
      cyc++;
      exp_out = '0;
      if (m_active && m_t >= 1 && m_t <= 16*m_p) begin
         for (int c = 0; c < NUM_CH; c++) begin
            int k;
            bit b;
            k = m_t - 1;
            b = m_frame[c][15 - k/m_p];
            exp_out[c] = ((k % m_p) < (b ? m_t1 : m_t0));
         end
      end
      chk("dshot_out", 32'(dshot_out), 32'(exp_out));
      chk("frame_ready", 32'(frame_ready), 32'(!m_active));
      chk("busy", 32'(busy), 32'(m_active));
      if (busy && !busy_prev) starts.push_back(cyc);
      busy_prev = busy;
      if (busy) busy_cnt++;
      if (dshot_out[0]) run++;
      else if (run > 0) begin
         widths.push_back(run);
         run = 0;
      end
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_valid();
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
   endtask

   // ch0 pulse widths of the last frame against the frame bits.
   task automatic check_widths(input logic [15:0] f, input int t1, input int t0);
      chk("width_count", 32'(widths.size()), 32'd16);
      for (int i = 0; i < 16 && i < widths.size(); i++)
         chk("width", 32'(widths[i]), 32'(f[15-i] ? t1 : t0));
   endtask

   int exp_w [16] = '{20,10,10,10,10,10,20,10,20,20,10,10,10,20,20,10};

   initial begin
      RST = 1'b1; mode = 2'd0; throttle = '0; telem = '0; frame_valid = 1'b0;
      run_n(3);
      RST = 1'b0;
      run_n(2);

      // Directed: DShot600, ch0 throttle 1046 -> 0x82C6
      mode = 2'd2; set_thr(0, 1046);
      widths.delete(); run = 0; busy_cnt = 0;
      pulse_valid();
      mode = 2'd0; set_thr(0, 5);
      run_n(16*27 + GAP + 4);
      chk("width_count", 32'(widths.size()), 32'd16);
      for (int i = 0; i < 16 && i < widths.size(); i++)
         chk("width_82c6", 32'(widths[i]), 32'(exp_w[i]));
      chk("busy_len", 32'(busy_cnt), 32'(16*27 + GAP));

      // All four modes, all-zero and all-ones frames
      for (int md = 0; md < 4; md++) begin
         for (int pat = 0; pat < 2; pat++) begin
            mode = 2'(md);
            for (int c = 0; c < NUM_CH; c++) set_thr(c, pat ? 2047 : 0);
            telem = pat ? '1 : '0;
            widths.delete(); run = 0;
            pulse_valid();
            run_n(16*period_of(md) + GAP + 3);
            check_widths(pat ? 16'hFFFF : 16'h0000, t1h_of(md), t1h_of(md)/2);
         end
      end

      // Back-to-back with valid held, distinct throttles
      mode = 2'd2; telem = 4'b0101;
      for (int c = 0; c < NUM_CH; c++) set_thr(c, 100 + 333*c);
      begin
         int s0;
         s0 = starts.size();
         frame_valid = 1'b1;
         run_n(3*(16*27 + GAP + 1) + 2);
         frame_valid = 1'b0;
         run_n(16*27 + GAP + 3);
         chk("b2b_frames", 32'(starts.size() - s0), 32'd4);
         for (int i = s0 + 1; i < starts.size(); i++)
            chk("b2b_spacing", 32'(starts[i] - starts[i-1]), 32'(16*27 + GAP + 1));
      end

      // Mid-frame change of mode and throttle
      mode = 2'd2; for (int c = 0; c < NUM_CH; c++) set_thr(c, 1500 - 7*c);
      pulse_valid();
      run_n(200);
      mode = 2'd1; for (int c = 0; c < NUM_CH; c++) set_thr(c, 42 + 500*c); telem = 4'b1010;
      run_n(16*27 + GAP);
      widths.delete(); run = 0;
      pulse_valid();
      run_n(16*53 + GAP + 3);
      check_widths(build(42, 1'b0), 40, 20);

      // Reset at bit 7, cycle 5 of an all-ones frame
      mode = 2'd2; for (int c = 0; c < NUM_CH; c++) set_thr(c, 2047); telem = '1;
      pulse_valid();
      run_n(7*27 + 5);
      RST = 1'b1;
      step();
      RST = 1'b0;
      run_n(40);
      pulse_valid();
      run_n(16*27 + GAP + 3);

      // Valid pulsed during GAP is ignored
      mode = 2'd3;
      pulse_valid();
      run_n(16*13 + 10);
      pulse_valid();
      run_n(GAP);

      // Randomised traffic with occasional mid-frame changes and resets
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            mode = 2'($urandom_range(0, 3));
            for (int c = 0; c < NUM_CH; c++) set_thr(c, int'($urandom_range(0, 2047)));
            telem = NUM_CH'($urandom);
         end
         frame_valid = ($urandom_range(0, 3) == 0);
         RST = ($urandom_range(0, 2999) == 0);
         step();
      end
      RST = 1'b0; frame_valid = 1'b0;
      run_n(16*107 + GAP + 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
